// File: rtl/multi_cycle_control.sv
// Main-control FSM for the multi-cycle datapath: sequences one instruction
// over a shared ALU and a unified memory port with a req/ready watchdog.
module multi_cycle_control #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] aluOp,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       bus_err
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_REXE   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_IEXE   = 4'd8;
  localparam logic [3:0] S_IWB    = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [3:0] state, state_nx;
  logic [3:0] iop, iop_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic       waiting, timeout, illegal;
  logic       unused_zero;

  // zero only matters to the datapath's pc_write_cond gating
  assign unused_zero = zero;

  assign waiting = (state == S_FETCH) ||
                   (state == S_MEMRD) ||
                   (state == S_MEMWR);
  assign timeout = waiting && !mem_ready &&
                   (wait_cnt >= WAIT_LAST);

  always_comb begin
    state_nx = state;
    iop_nx   = iop;
    illegal  = 1'b0;
    unique case (state)
      S_FETCH:
        if (mem_ready) state_nx = S_DECODE;
        else if (timeout) state_nx = S_FETCH;
      S_DECODE: begin
        state_nx = S_FETCH;
        case (opcode)
          OP_R:    state_nx = S_REXE;
          OP_LW:   state_nx = S_MEMADR;
          OP_SW:   state_nx = S_MEMADR;
          OP_BEQ:  state_nx = S_BRANCH;
          OP_J:    state_nx = S_JUMP;
          OP_ADDI: begin
            state_nx = S_IEXE;
            iop_nx   = 4'b1000;
          end
          OP_SLTI: begin
            state_nx = S_IEXE;
            iop_nx   = 4'b1010;
          end
          OP_ANDI: begin
            state_nx = S_IEXE;
            iop_nx   = 4'b1100;
          end
          OP_ORI: begin
            state_nx = S_IEXE;
            iop_nx   = 4'b1101;
          end
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR:
        state_nx = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:
        if (mem_ready) state_nx = S_MEMWB;
        else if (timeout) state_nx = S_FETCH;
      S_MEMWR:
        if (mem_ready || timeout) state_nx = S_FETCH;
      S_REXE:  state_nx = S_RWB;
      S_IEXE:  state_nx = S_IWB;
      default: state_nx = S_FETCH;
    endcase
  end

  // leaving a wait state (done or aborted) clears the watchdog
  assign wait_nx = (waiting && !mem_ready && !timeout) ?
                   wait_cnt + 8'd1 : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      iop      <= 4'b0000;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nx;
      iop      <= iop_nx;
      wait_cnt <= wait_nx;
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aluOp         = 4'b0000;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal_op    = 1'b0;
    bus_err       = timeout;
    unique case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = illegal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_REXE: begin
        alu_src_a = 1'b1;
        aluOp     = 4'b0010;
      end
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aluOp     = iop;
      end
      S_IWB:
        reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aluOp         = 4'b0001;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: ;
    endcase
    // everything quiet while held in reset
    if (!rst_n) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      aluOp         = 4'b0000;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      illegal_op    = 1'b0;
      bus_err       = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: directed cases then random
// instruction streams against an instruction-level reference model.
module tb_multi_cycle_control;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_n, mem_ready, zero;
  logic [5:0] opcode;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic       pc_write_cond, alu_src_a, reg_dst, mem_to_reg;
  logic       reg_write, illegal_op, bus_err;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] aluOp;

  int passes = 0;
  int fails  = 0;
  int checks = 0;

  typedef enum {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
    P_REXE, P_RWB, P_IEXE, P_IWB, P_BR, P_J
  } ph_t;

  multi_cycle_control #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .aluOp(aluOp), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal_op(illegal_op), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] imm_op(logic [5:0] op);
    case (op)
      6'b001000: return 4'b1000;
      6'b001010: return 4'b1010;
      6'b001100: return 4'b1100;
      6'b001101: return 4'b1101;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic [19:0] expv(ph_t p, bit rdy, bit to,
                                       bit ill, logic [3:0] iop);
    logic req = 0, we = 0, ad = 0, irw = 0, pcw = 0, pwc = 0;
    logic sa = 0, rd = 0, mtr = 0, rw = 0, il = 0, be = 0;
    logic [1:0] ps = 0, sb = 0;
    logic [3:0] ao = 0;
    case (p)
      P_FETCH: begin
        req = 1; sb = 2'b01; irw = rdy; pcw = rdy; be = to;
      end
      P_DECODE: begin sb = 2'b11; il = ill; end
      P_MEMADR: begin sa = 1; sb = 2'b10; end
      P_MEMRD:  begin req = 1; ad = 1; be = to; end
      P_MEMWB:  begin mtr = 1; rw = 1; end
      P_MEMWR:  begin req = 1; we = 1; ad = 1; be = to; end
      P_REXE:   begin sa = 1; ao = 4'b0010; end
      P_RWB:    begin rd = 1; rw = 1; end
      P_IEXE:   begin sa = 1; sb = 2'b10; ao = iop; end
      P_IWB:    rw = 1;
      P_BR: begin
        sa = 1; ao = 4'b0001; pwc = 1; ps = 2'b01;
      end
      P_J: begin pcw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {req, we, ad, irw, pcw, pwc, ps, sa, sb, ao,
            rd, mtr, rw, il, be};
  endfunction

  task automatic chk(string tag, logic [19:0] e);
    logic [19:0] o;
    o = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
         pc_src, alu_src_a, alu_src_b, aluOp,
         reg_dst, mem_to_reg, reg_write, illegal_op, bus_err};
    checks++;
    assert (o === e) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  // drive at the falling edge, check 1ns later, advance one cycle
  task automatic cyc(ph_t p, bit rdy, logic [5:0] opc, bit to,
                     bit ill, logic [3:0] iop, string tag);
    mem_ready = rdy;
    opcode    = opc;
    zero      = 1'($urandom);
    #1;
    chk(tag, expv(p, rdy, to, ill, iop));
    @(negedge clk);
  endtask

  task automatic mem_phase(ph_t p, int lat, string tag,
                           output bit ok);
    ok = 0;
    for (int k = 0; k < TO; k++) begin
      if (k == lat) begin
        cyc(p, 1, 6'($urandom), 0, 0, 0, tag);
        ok = 1;
        return;
      end
      cyc(p, 0, 6'($urandom), k == TO - 1, 0, 0, tag);
    end
  endtask

  task automatic run_instr(logic [5:0] op, int lat_f, int lat_m);
    bit ok;
    bit ill;
    mem_phase(P_FETCH, lat_f, "fetch", ok);
    if (!ok) mem_phase(P_FETCH, 0, "fetch_retry", ok);
    ill = !(op inside {6'b000000, 6'b100011, 6'b101011,
                       6'b000100, 6'b000010, 6'b001000,
                       6'b001010, 6'b001100, 6'b001101});
    cyc(P_DECODE, 1'($urandom), op, 0, ill, 0, "decode");
    case (op)
      6'b100011: begin
        cyc(P_MEMADR, 1'($urandom), op, 0, 0, 0, "lw_adr");
        mem_phase(P_MEMRD, lat_m, "lw_rd", ok);
        if (ok)
          cyc(P_MEMWB, 1'($urandom), 6'($urandom), 0, 0, 0, "lw_wb");
      end
      6'b101011: begin
        cyc(P_MEMADR, 1'($urandom), op, 0, 0, 0, "sw_adr");
        mem_phase(P_MEMWR, lat_m, "sw_wr", ok);
      end
      6'b000000: begin
        cyc(P_REXE, 1'($urandom), 6'($urandom), 0, 0, 0, "r_exe");
        cyc(P_RWB, 1'($urandom), 6'($urandom), 0, 0, 0, "r_wb");
      end
      6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
        cyc(P_IEXE, 1'($urandom), 6'($urandom), 0, 0,
            imm_op(op), "i_exe");
        cyc(P_IWB, 1'($urandom), 6'($urandom), 0, 0, 0, "i_wb");
      end
      6'b000100:
        cyc(P_BR, 1'($urandom), 6'($urandom), 0, 0, 0, "beq");
      6'b000010:
        cyc(P_J, 1'($urandom), 6'($urandom), 0, 0, 0, "jump");
      default: ;
    endcase
  endtask

  logic [5:0] ops [10];
  bit okv;

  initial begin
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
            6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b111111};
    rst_n = 0; mem_ready = 0; zero = 0; opcode = 0;
    #1;
    chk("reset_outputs", 20'd0);
    @(negedge clk);
    rst_n = 1;

    // fetch timeout right after reset, then retry
    run_instr(6'b000000, 20, 0);
    run_instr(6'b100011, 0, 0);
    run_instr(6'b001101, 0, 0);
    run_instr(6'b000000, 1, 0);
    zero = 1;
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b101011, 0, 20);
    run_instr(6'b101011, 0, 2);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b100011, 2, 20);

    // reset asserted for one cycle while in MEMRD
    mem_phase(P_FETCH, 0, "pre_fetch", okv);
    cyc(P_DECODE, 0, 6'b100011, 0, 0, 0, "pre_decode");
    cyc(P_MEMADR, 0, 6'b100011, 0, 0, 0, "pre_adr");
    cyc(P_MEMRD, 0, 6'b000000, 0, 0, 0, "pre_rd");
    rst_n = 0;
    #1;
    chk("reset_mid_memrd", 20'd0);
    @(negedge clk);
    rst_n = 1;
    run_instr(6'b100011, 20, 1);

    for (int i = 0; i < 150; i++) begin
      int lf, lm;
      logic [5:0] op;
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      lf = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
      lm = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 20)
                                       : $urandom_range(0, 3);
      run_instr(op, lf, lm);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
